// File: rtl/rsp_pkg.sv
// Shared types and limits for the req/ack responder.
package rsp_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_ACK  = 2'd2
  } rsp_state_t;

  localparam int ACK_MIN = 2;
  localparam int ACK_MAX = 3;

  // cnt value on the last edge that may still produce an ack (E2)
  localparam logic [1:0] CNT_LAST = 2'd2;

  function automatic logic [1:0] cnt_sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/rv_src_reg.sv
// Ready/valid source register: loads one word, holds it until accepted,
// then drops valid for at least one cycle.
module rv_src_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A load is only honoured while empty, so the accepting edge never refills.
    if (load_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/req_ack_responder.sv
// Responder end of the pulse req/ack handshake with a ready/valid output port.
// States: IDLE = waiting for req rise | WAIT = counting to ack decision | ACK = ack high one cycle
module req_ack_responder
  import rsp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACK_DLY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              err_overlap,
  output logic              err_timeout
);

  if (ACK_DLY < ACK_MIN || ACK_DLY > ACK_MAX) begin : g_bad_ack_dly
    $error("req_ack_responder: ACK_DLY must be in 2..3");
  end

  localparam logic [1:0] DLY_M1 = 2'(ACK_DLY - 1);

  rsp_state_t        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              req_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              ack_q, ack_d;
  logic              ovl_q, ovl_d;
  logic              tout_q, tout_d;
  logic              load;
  logic              rise;
  logic              req_held;

  assign rise     = req & ~req_q;
  // A fresh rise inside WAIT is a new request, not the original one still held.
  assign req_held = req & req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    ovl_d   = 1'b0;
    tout_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      RSP_IDLE: begin
        if (rise) begin
          if (m_valid) begin
            ovl_d = 1'b1;
          end else begin
            hold_d  = req_data;
            cnt_d   = 2'd1;
            state_d = RSP_WAIT;
          end
        end
      end
      RSP_WAIT: begin
        if (rise) begin
          ovl_d = 1'b1;
        end
        if (cnt_q >= DLY_M1 && !req_held) begin
          ack_d   = 1'b1;
          load    = 1'b1;
          cnt_d   = 2'd0;
          state_d = RSP_ACK;
        end else if (cnt_q >= CNT_LAST) begin
          tout_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = RSP_IDLE;
        end else begin
          cnt_d = cnt_sat_inc(cnt_q);
        end
      end
      RSP_ACK: begin
        if (rise) begin
          ovl_d = 1'b1;
        end
        state_d = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 2'd0;
      req_q   <= 1'b0;
      hold_q  <= '0;
      ack_q   <= 1'b0;
      ovl_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      ovl_q   <= ovl_d;
      tout_q  <= tout_d;
    end
  end

  rv_src_reg #(
    .DATA_W(DATA_W)
  ) u_src (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (hold_q),
    .ready_i(m_ready),
    .valid_o(m_valid),
    .data_o (m_data)
  );

  assign ack         = ack_q;
  assign err_overlap = ovl_q;
  assign err_timeout = tout_q;
  assign busy        = (state_q != RSP_IDLE) || m_valid;

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench: two responders (ACK_DLY=3 and 2) driven by the same initiator stimulus.
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] req_data = 8'h00;

  logic       ack_w  [2];
  logic       mv_w   [2];
  logic       busy_w [2];
  logic       ovl_w  [2];
  logic       tout_w [2];
  logic [7:0] md_w   [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit compliant = 1;
  bit rdy_rand = 0;

  // event kinds: 0 ack, 1 timeout, 2 overlap; entries are expected cycle numbers
  int         evt_q  [2][3][$];
  logic [7:0] word_q [2][$];
  bit         xfer_last [2];
  bit         hold_last [2];
  logic [7:0] data_last [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  req_ack_responder #(.DATA_W(8), .ACK_DLY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack_w[0]), .m_valid(mv_w[0]), .m_ready(m_ready), .m_data(md_w[0]),
    .busy(busy_w[0]), .err_overlap(ovl_w[0]), .err_timeout(tout_w[0])
  );

  req_ack_responder #(.DATA_W(8), .ACK_DLY(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack_w[1]), .m_valid(mv_w[1]), .m_ready(m_ready), .m_data(md_w[1]),
    .busy(busy_w[1]), .err_overlap(ovl_w[1]), .err_timeout(tout_w[1])
  );

  function automatic int dly_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_evt(input int i, input int k, input logic seen, input string nm);
    string n;
    n = $sformatf("dly%0d %s", dly_of(i), nm);
    if (seen) begin
      if (evt_q[i][k].size() == 0) chk({n, " unexpected at cycle"}, cyc, -1);
      else chk({n, " cycle"}, cyc, evt_q[i][k].pop_front());
    end else if (evt_q[i][k].size() > 0 && evt_q[i][k][0] < cyc) begin
      chk({n, " missing at cycle"}, -1, evt_q[i][k].pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!mon_en) begin
        xfer_last[i] = 0;
        hold_last[i] = 0;
      end else begin
        chk_evt(i, 0, ack_w[i], "ack");
        chk_evt(i, 1, tout_w[i], "err_timeout");
        chk_evt(i, 2, ovl_w[i], "err_overlap");
        if (ack_w[i]) chk($sformatf("dly%0d m_valid with ack", dly_of(i)), mv_w[i], 1);
        if (xfer_last[i]) chk($sformatf("dly%0d m_valid after transfer", dly_of(i)), mv_w[i], 0);
        if (hold_last[i]) begin
          chk($sformatf("dly%0d m_valid held", dly_of(i)), mv_w[i], 1);
          chk($sformatf("dly%0d m_data stable", dly_of(i)), md_w[i], data_last[i]);
        end
        if (mv_w[i] && m_ready) begin
          if (word_q[i].size() == 0) chk($sformatf("dly%0d unexpected word", dly_of(i)), md_w[i], -1);
          else chk($sformatf("dly%0d word", dly_of(i)), md_w[i], word_q[i].pop_front());
        end
        xfer_last[i] = mv_w[i] && m_ready;
        hold_last[i] = mv_w[i] && !m_ready;
        data_last[i] = md_w[i];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_prop
    a_ack_pulse: assert property (@(posedge clk) disable iff (rst) ack_w[g] |=> !ack_w[g])
      else begin errors++; $display("FAIL assert ack_pulse dut%0d", g); end
    a_hold: assert property (@(posedge clk) disable iff (rst)
        mv_w[g] && !m_ready |=> mv_w[g] && md_w[g] == $past(md_w[g]))
      else begin errors++; $display("FAIL assert valid_hold dut%0d", g); end
    a_release: assert property (@(posedge clk) disable iff (rst) mv_w[g] && m_ready |=> !mv_w[g])
      else begin errors++; $display("FAIL assert release dut%0d", g); end
    a_req_ack: assert property (@(posedge clk) disable iff (rst) compliant |-> !(req && ack_w[g]))
      else begin errors++; $display("FAIL assert req_and_ack dut%0d", g); end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit pending();
    bit p;
    p = 0;
    for (int i = 0; i < 2; i++) begin
      if (word_q[i].size() != 0 || mv_w[i] || busy_w[i]) p = 1;
      for (int k = 0; k < 3; k++) if (evt_q[i][k].size() != 0) p = 1;
    end
    return p;
  endfunction

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (pending() && t < budget) begin
      step();
      t++;
    end
    chk("drain pending", int'(pending()), 0);
  endtask

  // Expected outcome from the timing rules: the ack decision edge is the first
  // edge n >= ACK_DLY-1 at which req is low; past E2 the request times out.
  task automatic issue(input int h, input logic [7:0] d);
    int p;
    int n;
    step();
    p = cyc;
    req = 1'b1;
    req_data = d;
    for (int i = 0; i < 2; i++) begin
      n = (dly_of(i) - 1 > h) ? dly_of(i) - 1 : h;
      if (n <= 2) begin
        evt_q[i][0].push_back(p + 1 + n);
        word_q[i].push_back(d);
      end else begin
        evt_q[i][1].push_back(p + 1 + 2);
      end
    end
    repeat (h) step();
    req = 1'b0;
    req_data = 8'($urandom);
  endtask

  task automatic chk_zero_after_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s dly%0d ack", tag, dly_of(i)), ack_w[i], 0);
      chk($sformatf("%s dly%0d m_valid", tag, dly_of(i)), mv_w[i], 0);
      chk($sformatf("%s dly%0d busy", tag, dly_of(i)), busy_w[i], 0);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 2; i++) begin
      word_q[i].delete();
      for (int k = 0; k < 3; k++) evt_q[i][k].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dly%0d ack", dly_of(i)), ack_w[i], 0);
      chk($sformatf("reset dly%0d m_valid", dly_of(i)), mv_w[i], 0);
      chk($sformatf("reset dly%0d m_data", dly_of(i)), md_w[i], 0);
      chk($sformatf("reset dly%0d busy", dly_of(i)), busy_w[i], 0);
      chk($sformatf("reset dly%0d err_overlap", dly_of(i)), ovl_w[i], 0);
      chk($sformatf("reset dly%0d err_timeout", dly_of(i)), tout_w[i], 0);
    end
    step();
    rst = 1'b0;
    step();
    mon_en = 1;

    // single pulse, consumer stalls four cycles
    m_ready = 1'b0;
    issue(1, 8'hA5);
    repeat (4) step();
    m_ready = 1'b1;
    drain(50);

    // req held two edges: one retry for ACK_DLY=2, normal for ACK_DLY=3
    issue(2, 8'h3C);
    drain(50);

    // req held three edges: timeout on both
    issue(3, 8'h5A);
    drain(50);

    // new rise while the word is still waiting for the consumer
    compliant = 0;
    m_ready = 1'b0;
    issue(1, 8'h11);
    step();
    step();
    req = 1'b1;
    for (int i = 0; i < 2; i++) evt_q[i][2].push_back(cyc + 1);
    step();
    req = 1'b0;
    repeat (3) step();
    m_ready = 1'b1;
    drain(50);

    // new rise two edges after the first one, before/around the ack
    step();
    p = cyc;
    req = 1'b1;
    req_data = 8'h77;
    evt_q[0][0].push_back(p + 3);
    evt_q[1][0].push_back(p + 2);
    for (int i = 0; i < 2; i++) begin
      word_q[i].push_back(8'h77);
      evt_q[i][2].push_back(p + 3);
    end
    step();
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    drain(50);
    compliant = 1;

    // reset while waiting for the ack decision
    mon_en = 0;
    step();
    req = 1'b1;
    req_data = 8'hC3;
    step();
    req = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("pre-reset WAIT dly%0d busy", dly_of(i)), busy_w[i], 1);
    rst = 1'b1;
    #1;
    chk_zero_after_reset("reset in WAIT");
    step();
    rst = 1'b0;
    clear_queues();
    step();

    // reset while ACK_DLY=3 has ack high and ACK_DLY=2 holds its word
    m_ready = 1'b0;
    req = 1'b1;
    req_data = 8'h3E;
    step();
    req = 1'b0;
    step();
    step();
    chk("pre-reset ACK dly3 ack", ack_w[0], 1);
    chk("pre-reset ACK dly2 m_valid", mv_w[1], 1);
    rst = 1'b1;
    #1;
    chk_zero_after_reset("reset in ACK");
    step();
    rst = 1'b0;
    clear_queues();
    step();
    mon_en = 1;
    m_ready = 1'b1;
    issue(1, 8'h96);
    drain(50);

    // randomly spaced transactions with a random consumer
    rdy_rand = 1;
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(1, 4)) step();
      issue(int'($urandom_range(1, 3)), 8'($urandom));
      drain(80);
    end
    rdy_rand = 0;
    m_ready = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
